// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 1..3-word instructions, holds them for execution, handles halt/resume
module fetch_sequencer #(
  parameter int         ADDR_W    = 16,
  parameter logic [7:0] LEN2_OP_A = 8'h01,
  parameter logic [7:0] LEN2_OP_B = 8'hD0,
  parameter logic [7:0] LEN3_OP   = 8'hD1,
  parameter logic [7:0] OP_HLT    = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       memdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] memaddr,
  input  logic              exec_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              resume,
  output logic [31:0]       instr0,
  output logic [31:0]       instr1,
  output logic [31:0]       instr2,
  output logic [1:0]        instr_len,
  output logic              instr_valid,
  output logic [2:0]        current_state,
  output logic [7:0]        cr,
  output logic [ADDR_W-1:0] pc
);
  typedef enum logic [2:0] {FETCH0 = 3'd0, FETCH1 = 3'd1, FETCH2 = 3'd2, EXEC = 3'd3, HALT = 3'd4} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       i0_q, i0_d, i1_q, i1_d, i2_q, i2_d;
  logic [1:0]        len_q, len_d, dec_len;
  logic              hlt_q, hlt_d, wrap_q, wrap_d;
  logic              fetching;
  assign fetching = state_q == FETCH0 || state_q == FETCH1 || state_q == FETCH2;
  assign dec_len = memdata[31:24] == LEN3_OP ? 2'd3 :
                   (memdata[31:24] == LEN2_OP_A || memdata[31:24] == LEN2_OP_B) ? 2'd2 : 2'd1;
  assign mem_req = fetching;
  assign memaddr = fetching ? pc_q : '0;
  assign instr0 = i0_q;
  assign instr1 = i1_q;
  assign instr2 = i2_q;
  assign instr_len = len_q;
  assign instr_valid = state_q == EXEC;
  assign current_state = state_q;
  assign cr = {6'b0, wrap_q, hlt_q};
  assign pc = pc_q;
  // next-state: word capture on accepted fetches, exec completion, halt/resume
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    i0_d = i0_q;
    i1_d = i1_q;
    i2_d = i2_q;
    len_d = len_q;
    hlt_d = hlt_q;
    wrap_d = wrap_q;
    case (state_q)
      FETCH0: if (mem_ack) begin
        i0_d = memdata;
        i1_d = '0;
        i2_d = '0;
        len_d = dec_len;
        state_d = dec_len >= 2'd2 ? FETCH1 : EXEC;
      end
      FETCH1: if (mem_ack) begin
        i1_d = memdata;
        state_d = len_q == 2'd3 ? FETCH2 : EXEC;
      end
      FETCH2: if (mem_ack) begin
        i2_d = memdata;
        state_d = EXEC;
      end
      EXEC: if (exec_done) begin
        pc_d = pc_load ? pc_load_val : pc_q;
        hlt_d = i0_q[31:24] == OP_HLT ? 1'b1 : hlt_q;
        state_d = i0_q[31:24] == OP_HLT ? HALT : FETCH0;
      end
      HALT: if (resume) begin
        hlt_d = 1'b0;
        state_d = FETCH0;
      end
      default: state_d = FETCH0;
    endcase
    if (fetching && mem_ack) begin
      pc_d = pc_q + 1'b1;
      wrap_d = wrap_q | (&pc_q);
    end
  end
  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH0;
      pc_q <= '0;
      i0_q <= '0;
      i1_q <= '0;
      i2_q <= '0;
      len_q <= 2'd1;
      hlt_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      i0_q <= i0_d;
      i1_q <= i1_d;
      i2_q <= i2_d;
      len_q <= len_d;
      hlt_q <= hlt_d;
      wrap_q <= wrap_d;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus random traffic against an instruction-level model
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req;
  logic [15:0] memaddr;
  logic        exec_done = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = '0;
  logic        resume = 1'b0;
  logic [31:0] instr0, instr1, instr2;
  logic [1:0]  instr_len;
  logic        instr_valid;
  logic [2:0]  current_state;
  logic [7:0]  cr;
  logic [15:0] pc;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .memdata(memdata), .mem_ack(mem_ack), .mem_req(mem_req),
    .memaddr(memaddr), .exec_done(exec_done), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .resume(resume), .instr0(instr0), .instr1(instr1), .instr2(instr2), .instr_len(instr_len),
    .instr_valid(instr_valid), .current_state(current_state), .cr(cr), .pc(pc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // model: pc, held words, words fetched so far, and mode (0 fetching, 1 executing, 2 halted)
  int          m_pc, m_len, m_cnt, m_mode;
  logic [31:0] m_w [3];
  bit          m_hlt, m_wrap;

  function automatic int len_of(input logic [7:0] op);
    return op == 8'hD1 ? 3 : (op == 8'h01 || op == 8'hD0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_len = 1; m_cnt = 0; m_mode = 0; m_hlt = 0; m_wrap = 0;
    m_w[0] = '0; m_w[1] = '0; m_w[2] = '0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (!reset) model_reset();
    else if (m_mode == 0) begin
      if (mem_ack) begin
        w = mem[m_pc];
        if (m_cnt == 0) begin
          m_len = len_of(w[31:24]);
          m_w[0] = w; m_w[1] = '0; m_w[2] = '0;
        end else m_w[m_cnt] = w;
        if (m_pc == 65535) m_wrap = 1;
        m_pc = (m_pc + 1) % 65536;
        m_cnt++;
        if (m_cnt == m_len) m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (exec_done) begin
        if (pc_load) m_pc = int'(pc_load_val);
        if (m_w[0][31:24] == 8'hFF) begin m_mode = 2; m_hlt = 1; end
        else begin m_mode = 0; m_cnt = 0; end
      end
    end else if (resume) begin
      m_hlt = 0; m_mode = 0; m_cnt = 0;
    end
  endtask

  // compare every visible output against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", {29'b0, current_state}, m_mode == 0 ? m_cnt : m_mode == 1 ? 3 : 4);
      chk("mem_req", {31'b0, mem_req}, {31'b0, m_mode == 0});
      chk("memaddr", {16'b0, memaddr}, m_mode == 0 ? m_pc : 0);
      chk("pc", {16'b0, pc}, m_pc);
      chk("instr0", instr0, m_w[0]);
      chk("instr1", instr1, m_w[1]);
      chk("instr2", instr2, m_w[2]);
      chk("instr_len", {30'b0, instr_len}, m_len);
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_mode == 1});
      chk("cr", {24'b0, cr}, {30'b0, m_wrap, m_hlt});
    end
  end

  task automatic cyc(input logic a, input logic d, input logic l, input logic [15:0] v, input logic r);
    mem_ack = a; exec_done = d; pc_load = l; pc_load_val = v; resume = r;
    memdata = mem[memaddr];
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [7:0] op;
    int k = $urandom_range(0, 7);
    op = k == 0 ? 8'h01 : k == 1 ? 8'hD0 : k == 2 ? 8'hD1 : k == 3 ? 8'hFF : 8'($urandom_range(0, 255));
    return {op, 24'($urandom)};
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = rand_word();
    mem[0] = 32'h1000_0000; mem[1] = 32'h0100_0000; mem[2] = 32'h0000_ABCD;
    mem[5] = 32'hD100_0000; mem[6] = 32'h1111_2222; mem[7] = 32'h3333_4444;
    mem[16'h40] = 32'h1000_0000; mem[16'h20] = 32'hFF00_0000; mem[16'h21] = 32'h1000_0000;
    mem[16'hFFFF] = 32'hFF00_0000;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_state", {29'b0, current_state}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd1);
    chk("rst_memaddr", {16'b0, memaddr}, 32'd0);
    chk("rst_len", {30'b0, instr_len}, 32'd1);
    chk("rst_cr", {24'b0, cr}, 32'd0);
    chk_en = 1'b1;
    reset = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("d1_len", {30'b0, instr_len}, 32'd1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("d1_len2", {30'b0, instr_len}, 32'd2);
    chk("d1_instr1", instr1, 32'h0000_ABCD);
    chk("d1_pc", {16'b0, pc}, 32'd3);
    cyc(0, 0, 1, 16'h0040, 0);
    chk("d2_pc_hold", {16'b0, pc}, 32'd3);
    cyc(0, 1, 1, 16'h0040, 0);
    chk("d2_memaddr", {16'b0, memaddr}, 32'h40);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 16'd5, 0);
    for (int k = 0; k < 3; k++) begin
      repeat (2) begin
        cyc(0, 0, 0, 0, 0);
        chk("d3_wait_addr", {16'b0, memaddr}, 32'(5 + k));
      end
      cyc(1, 0, 0, 0, 0);
    end
    chk("d3_state", {29'b0, current_state}, 32'd3);
    chk("d3_len", {30'b0, instr_len}, 32'd3);
    chk("d3_pc", {16'b0, pc}, 32'd8);
    chk("d3_instr2", instr2, 32'h3333_4444);
    cyc(0, 1, 1, 16'h0020, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("d4_state", {29'b0, current_state}, 32'd4);
    chk("d4_cr", {24'b0, cr}, 32'h01);
    chk("d4_mem_req", {31'b0, mem_req}, 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("d4_resume_state", {29'b0, current_state}, 32'd0);
    chk("d4_resume_cr", {24'b0, cr}, 32'h00);
    chk("d4_resume_pc", {16'b0, pc}, 32'h21);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 16'hFFFF, 0);
    cyc(1, 0, 0, 0, 0);
    chk("d5_wrap_pc", {16'b0, pc}, 32'd0);
    chk("d5_wrap_cr", {24'b0, cr}, 32'h02);
    cyc(0, 1, 0, 0, 0);
    chk("d5_halt_cr", {24'b0, cr}, 32'h03);
    cyc(0, 0, 0, 0, 1);
    chk("d5_sticky_cr", {24'b0, cr}, 32'h02);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("d6_state_f1", {29'b0, current_state}, 32'd1);
    mem_ack = 0; exec_done = 0; pc_load = 0; resume = 0;
    @(posedge clk);
    model_step();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("d6_async_state", {29'b0, current_state}, 32'd0);
    chk("d6_async_pc", {16'b0, pc}, 32'd0);
    chk("d6_async_cr", {24'b0, cr}, 32'd0);
    chk("d6_async_instr0", instr0, 32'd0);
    chk("d6_async_len", {30'b0, instr_len}, 32'd1);
    chk("d6_async_memaddr", {16'b0, memaddr}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("d6_after_pc", {16'b0, pc}, 32'd1);
    for (int n = 0; n < 4000; n++)
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3,
          16'($urandom), $urandom_range(0, 9) < 4);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
